// File: rtl/placer_load_sequencer.sv
// ---------------------------------------------------------------------------
// placer_load_sequencer
//
// On-chip sequencer for the systolic placer's load/run/unload bus. It reads
// the bitstream out of a word memory and streams it into the placer as
// NUM_OF_PACKETS packets of PACKET_LENGTH words. Each packet is preceded by a
// PACKET_DELAY idle gap. After a FIXED_DELAY settle period it fires a
// one-cycle run trigger. It then captures every unload word the placer
// presents while 'complete' is high.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start, abort        begin a sequence (IDLE only) / return to IDLE
//   busy, done          sequence in progress / one-cycle end-of-unload pulse
//   mem_rd_en, mem_addr, mem_rd_data
//                       bitstream memory read port (1-cycle read latency)
//   load_enable_out, load_out
//                       placer load bus (enable marks word 0 and the trigger)
//   complete_in, unload_in
//                       placer completion flag and unload data
//   unload_valid, unload_data, unload_count
//                       captured unload words and a saturating word count
// ---------------------------------------------------------------------------
module placer_load_sequencer #(
    parameter int BUS_WIDTH      = 32,
    parameter int N              = 16,
    parameter int HEADER_LENGTH  = 1,
    parameter int PACKET_LENGTH  = 8 + N,
    parameter int NUM_OF_PACKETS = N + 2,
    parameter int PACKET_DELAY   = 20,
    parameter int FIXED_DELAY    = 10,
    parameter int ADDR_WIDTH     = $clog2(HEADER_LENGTH + PACKET_LENGTH * NUM_OF_PACKETS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0]  mem_rd_data,
    output logic                  load_enable_out,
    output logic [BUS_WIDTH-1:0]  load_out,
    input  logic                  complete_in,
    input  logic [BUS_WIDTH-1:0]  unload_in,
    output logic                  unload_valid,
    output logic [BUS_WIDTH-1:0]  unload_data,
    output logic [15:0]           unload_count
);

    localparam int MAX_DELAY = (PACKET_DELAY > FIXED_DELAY) ? PACKET_DELAY : FIXED_DELAY;
    localparam int DLY_W     = $clog2(MAX_DELAY + 1);
    localparam int WORD_W    = $clog2(PACKET_LENGTH + 1);
    localparam int PKT_W     = $clog2(NUM_OF_PACKETS + 1);

    localparam logic [DLY_W-1:0]      GAP_LAST    = DLY_W'(PACKET_DELAY - 1);
    localparam logic [DLY_W-1:0]      SETTLE_LAST = DLY_W'(FIXED_DELAY - 1);
    localparam logic [WORD_W-1:0]     WORD_LAST   = WORD_W'(PACKET_LENGTH - 1);
    localparam logic [PKT_W-1:0]      PKT_LAST    = PKT_W'(NUM_OF_PACKETS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_START  = ADDR_WIDTH'(HEADER_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_STREAM,
        ST_SETTLE,
        ST_TRIGGER,
        ST_WAIT_RUN,
        ST_UNLOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [DLY_W-1:0]        delay_cnt_q, delay_cnt_d;
    logic [WORD_W-1:0]       word_cnt_q, word_cnt_d;
    logic [PKT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

    // Load pipeline: stage 1 marks "memory answers this cycle", stage 2 is
    // the registered placer bus.
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_first_q, rd_first_d;
    logic                    trig_q, trig_d;
    logic                    load_en_q, load_en_d;
    logic [BUS_WIDTH-1:0]    load_out_q, load_out_d;

    logic                    unload_valid_q, unload_valid_d;
    logic [BUS_WIDTH-1:0]    unload_data_q, unload_data_d;
    logic [15:0]             unload_count_q, unload_count_d;
    logic                    done_q, done_d;

    logic                    rd_en;
    logic                    first_word;
    logic                    trigger;
    logic                    capture;

    // Next-state logic. The FSM decides when to read, when to trigger and
    // when to capture. An abort then overrides everything so the following
    // cycle is a clean IDLE with the in-flight load words discarded.
    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        word_cnt_d     = word_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        mem_addr_d     = mem_addr_q;
        rd_en          = 1'b0;
        first_word     = 1'b0;
        trigger        = 1'b0;
        capture        = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_addr_d  = ADDR_START;
                    pkt_cnt_d   = '0;
                    delay_cnt_d = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // The packet's first read is issued in the final gap cycle.
                if (delay_cnt_q == GAP_LAST) begin
                    rd_en       = 1'b1;
                    first_word  = 1'b1;
                    delay_cnt_d = '0;
                    word_cnt_d  = WORD_W'(1);
                    state_d     = ST_STREAM;
                end else begin
                    delay_cnt_d = delay_cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                rd_en = 1'b1;
                if (word_cnt_q == WORD_LAST) begin
                    pkt_cnt_d   = pkt_cnt_q + 1'b1;
                    delay_cnt_d = '0;
                    state_d     = (pkt_cnt_q == PKT_LAST) ? ST_SETTLE : ST_GAP;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (delay_cnt_q == SETTLE_LAST) begin
                    delay_cnt_d = '0;
                    state_d     = ST_TRIGGER;
                end else begin
                    delay_cnt_d = delay_cnt_q + 1'b1;
                end
            end
            ST_TRIGGER: begin
                trigger = 1'b1;
                state_d = ST_WAIT_RUN;
            end
            ST_WAIT_RUN: begin
                if (complete_in) begin
                    capture = 1'b1;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (complete_in) begin
                    capture = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            rd_en   = 1'b0;
            trigger = 1'b0;
            capture = 1'b0;
            done_d  = 1'b0;
        end

        if (rd_en) begin
            mem_addr_d = mem_addr_q + 1'b1;
        end
    end

    // Load and unload datapath. Word 0 of each packet and the trigger share
    // the same pipeline. So the trigger lands on the bus two cycles after the
    // TRIGGER state, just as a word lands two cycles after its read.
    always_comb begin
        rd_valid_d     = rd_en;
        rd_first_d     = first_word;
        trig_d         = trigger;
        load_out_d     = rd_valid_q ? mem_rd_data : '0;
        load_en_d      = (rd_valid_q & rd_first_q) | trig_q;
        unload_valid_d = capture;
        unload_data_d  = unload_data_q;
        unload_count_d = unload_count_q;

        if (state_q == ST_IDLE && start && !abort) begin
            unload_count_d = '0;
        end

        if (capture) begin
            unload_data_d = unload_in;
            if (unload_count_q != 16'hFFFF) begin
                unload_count_d = unload_count_q + 16'd1;
            end
        end

        if (abort) begin
            load_out_d = '0;
            load_en_d  = 1'b0;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            delay_cnt_q    <= '0;
            word_cnt_q     <= '0;
            pkt_cnt_q      <= '0;
            mem_addr_q     <= ADDR_START;
            rd_valid_q     <= 1'b0;
            rd_first_q     <= 1'b0;
            trig_q         <= 1'b0;
            load_en_q      <= 1'b0;
            load_out_q     <= '0;
            unload_valid_q <= 1'b0;
            unload_data_q  <= '0;
            unload_count_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_cnt_q    <= delay_cnt_d;
            word_cnt_q     <= word_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            mem_addr_q     <= mem_addr_d;
            rd_valid_q     <= rd_valid_d;
            rd_first_q     <= rd_first_d;
            trig_q         <= trig_d;
            load_en_q      <= load_en_d;
            load_out_q     <= load_out_d;
            unload_valid_q <= unload_valid_d;
            unload_data_q  <= unload_data_d;
            unload_count_q <= unload_count_d;
            done_q         <= done_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign mem_rd_en       = rd_en;
    assign mem_addr        = mem_addr_q;
    assign load_enable_out = load_en_q;
    assign load_out        = load_out_q;
    assign unload_valid    = unload_valid_q;
    assign unload_data     = unload_data_q;
    assign unload_count    = unload_count_q;

endmodule

// File: tb/tb_placer_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_placer_load_sequencer
//
// Directed bench for placer_load_sequencer with N=2. The configuration is
// PACKET_LENGTH=10, 4 packets, 20-cycle gaps and a 10-cycle settle. The
// bitstream memory holds word i at address i. Packet p word w therefore
// appears on load_out in cycle 29*p+21+w after start, with value 10*p+w+1.
// The trigger pulse lands in cycle 128.
// ---------------------------------------------------------------------------
module tb_placer_load_sequencer;

    localparam int BW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rd_data = '0;
    logic          load_enable_out;
    logic [BW-1:0] load_out;
    logic          complete_in;
    logic [BW-1:0] unload_in;
    logic          unload_valid;
    logic [BW-1:0] unload_data;
    logic [15:0]   unload_count;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int exp_out, exp_en, exp_rd, base, en_seen;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Bitstream memory model: word i holds value i, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= BW'(mem_addr);
    end

    placer_load_sequencer #(
        .BUS_WIDTH (BW),
        .N         (2),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .load_enable_out(load_enable_out),
        .load_out       (load_out),
        .complete_in    (complete_in),
        .unload_in      (unload_in),
        .unload_valid   (unload_valid),
        .unload_data    (unload_data),
        .unload_count   (unload_count)
    );

    // Drive all sequencer inputs at once.
    task automatic applyStimulus(input logic s, input logic a, input logic c,
                                 input logic [BW-1:0] u);
        start       = s;
        abort       = a;
        complete_in = c;
        unload_in   = u;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // One comparison point: count it, and report a mismatch.
    task automatic checkOutput(input string tag, input logic [BW-1:0] obs,
                               input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s (cycle %0d): observed %0d expected %0d",
                   tag, cycle, obs, exp);
        end
    endtask

    // Hand-derived load-bus timing for one full sequence started at cycle 0.
    task automatic expectedLoad(input int k);
        exp_out = 0;
        exp_en  = 0;
        exp_rd  = 0;
        for (int p = 0; p < 4; p++) begin
            base = 29 * p + 21;
            if (k >= base && k < base + 10) begin
                exp_out = 10 * p + (k - base) + 1;
                exp_en  = (k == base) ? 1 : 0;
            end
            if (k >= base - 2 && k < base + 8) exp_rd = 1;
        end
        if (k == 128) exp_en = 1;
    endtask

    initial begin
        // Reset held low with start asserted: everything stays at reset values.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycle();
        waitCycle();
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_load_en", {31'b0, load_enable_out}, 0);
        checkOutput("rst_load_out", load_out, 0);
        checkOutput("rst_rd_en", {31'b0, mem_rd_en}, 0);
        checkOutput("rst_done", {31'b0, done}, 0);
        checkOutput("rst_unload_valid", {31'b0, unload_valid}, 0);
        checkOutput("rst_unload_count", {16'b0, unload_count}, 0);
        checkOutput("rst_addr", {26'b0, mem_addr}, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        waitCycle();
        checkOutput("post_rst_addr", {26'b0, mem_addr}, 1);
        checkOutput("post_rst_busy", {31'b0, busy}, 0);

        // Full load. A second start mid-STREAM and a stray complete pulse
        // during the first gap must both be ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycle();
        cycle   = 0;
        en_seen = 0;
        for (int k = 0; k <= 130; k++) begin
            expectedLoad(k);
            checkOutput("load_out", load_out, BW'(exp_out));
            checkOutput("load_en", {31'b0, load_enable_out}, BW'(exp_en));
            checkOutput("rd_en", {31'b0, mem_rd_en}, BW'(exp_rd));
            checkOutput("busy_run", {31'b0, busy}, 1);
            checkOutput("unload_valid_run", {31'b0, unload_valid}, 0);
            if (k < 128 && load_enable_out) en_seen++;
            applyStimulus(k == 25, 1'b0, (k >= 5 && k <= 7), '0);
            waitCycle();
        end
        checkOutput("packet_count", BW'(en_seen), 4);
        checkOutput("end_addr", {26'b0, mem_addr}, 41);
        checkOutput("wait_busy", {31'b0, busy}, 1);

        // Unload burst of 5 words, 100..104.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, BW'(100 + i));
            waitCycle();
            checkOutput("unload_valid", {31'b0, unload_valid}, 1);
            checkOutput("unload_data", unload_data, BW'(100 + i));
            checkOutput("unload_count", {16'b0, unload_count}, BW'(i + 1));
            checkOutput("unload_no_done", {31'b0, done}, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        waitCycle();
        checkOutput("done_pulse", {31'b0, done}, 1);
        checkOutput("done_valid", {31'b0, unload_valid}, 0);
        checkOutput("done_busy", {31'b0, busy}, 0);
        checkOutput("final_count", {16'b0, unload_count}, 5);
        waitCycle();
        checkOutput("done_single", {31'b0, done}, 0);
        checkOutput("idle_busy", {31'b0, busy}, 0);

        // Abort in the middle of packet 2 (its words are on the bus from cycle 50).
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycle();
        cycle = 0;
        for (int k = 0; k <= 52; k++) begin
            if (k == 50) begin
                checkOutput("pkt2_load_en", {31'b0, load_enable_out}, 1);
                checkOutput("pkt2_load_out", load_out, 11);
            end
            applyStimulus(1'b0, k == 52, 1'b0, '0);
            waitCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_busy", {31'b0, busy}, 0);
        checkOutput("abort_load_en", {31'b0, load_enable_out}, 0);
        checkOutput("abort_rd_en", {31'b0, mem_rd_en}, 0);
        checkOutput("abort_load_out", load_out, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_no_done", {31'b0, done}, 0);
            waitCycle();
        end

        // Restart reloads from the header offset and runs to WAIT_RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        cycle = 0;
        checkOutput("restart_addr", {26'b0, mem_addr}, 1);
        checkOutput("restart_count", {16'b0, unload_count}, 0);
        for (int k = 0; k <= 130; k++) begin
            if (k == 19) begin
                checkOutput("restart_rd_en", {31'b0, mem_rd_en}, 1);
                checkOutput("restart_rd_addr", {26'b0, mem_addr}, 1);
            end
            if (k == 21) begin
                checkOutput("restart_load_en", {31'b0, load_enable_out}, 1);
                checkOutput("restart_load_out", load_out, 1);
            end
            waitCycle();
        end
        checkOutput("wait2_busy", {31'b0, busy}, 1);
        checkOutput("wait2_addr", {26'b0, mem_addr}, 41);
        checkOutput("wait2_data", unload_data, 104);

        // Asynchronous reset between clock edges while waiting for the run.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_busy", {31'b0, busy}, 0);
        checkOutput("async_addr", {26'b0, mem_addr}, 1);
        checkOutput("async_data", unload_data, 0);
        checkOutput("async_load_en", {31'b0, load_enable_out}, 0);
        checkOutput("async_rd_en", {31'b0, mem_rd_en}, 0);
        waitCycle();
        rst = 1'b1;
        waitCycle();
        checkOutput("async_release_busy", {31'b0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
